// File: rtl/c1908_pkg.sv
// Shared constants and types for the c1908-compatible 16-bit SEC/DED decoder:
// codeword position map, widths and the error classification type.
package c1908_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHK_W  = 6;
  // Codeword vector: bit 0 holds overall parity c5, bits 1..21 are Hamming positions
  localparam int unsigned CW_W   = 22;

  typedef logic [4:0] pos_t;

  localparam pos_t DATA_POS [DATA_W] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  localparam pos_t CHK_POS [CHK_W-1] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  localparam pos_t MAX_POS = 5'd21;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    SINGLE = 2'b01,
    DOUBLE = 2'b10
  } err_class_t;

  function automatic logic parity(input logic [CW_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/c1908_syndrome.sv
// Combinational syndrome generator: builds the received codeword from data and
// (optionally inverted) check bits and returns {overall parity, s[4:0]}.
module c1908_syndrome
  import c1908_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  chk,
  input  logic              inv_chk,
  output logic [CHK_W-1:0]  syn_raw
);

  logic [CHK_W-1:0] chk_eff_s;
  logic [CW_W-1:0]  cw_s;
  logic [4:0]       s_s;

  // Place bits at their codeword positions, then XOR the positions of all set bits
  always_comb begin
    chk_eff_s = inv_chk ? ~chk : chk;
    cw_s      = '0;
    cw_s[0]   = chk_eff_s[CHK_W-1];
    for (int i = 0; i < DATA_W; i++) begin
      cw_s[DATA_POS[i]] = data[i];
    end
    for (int k = 0; k < CHK_W - 1; k++) begin
      cw_s[CHK_POS[k]] = chk_eff_s[k];
    end
    s_s = 5'd0;
    for (int p = 1; p < CW_W; p++) begin
      s_s = s_s ^ ({5{cw_s[p]}} & 5'(p));
    end
    syn_raw = {parity(cw_s), s_s};
  end

endmodule

// File: rtl/c1908_sec_ded.sv
// Registered SEC/DED decoder with the ISCAS-85 c1908 pin map.
// Define C1908_IN_REG_EN to add an input register stage (2-cycle latency).
module c1908_sec_ded
  import c1908_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic N1, N4, N7, N10, N13, N16, N19, N22,
  input  logic N25, N28, N31, N34, N37, N40, N43, N46,
  input  logic N49, N53, N56, N60, N63, N66,
  input  logic N69, N72, N76, N79, N82,
  input  logic N85, N88, N91, N94, N99, N104,
  output logic N2753, N2754, N2755, N2756, N2762, N2767, N2768, N2779,
  output logic N2780, N2781, N2782, N2783, N2784, N2785, N2786, N2787,
  output logic N2811,
  output logic N2886, N2887, N2888, N2889, N2890, N2891,
  output logic N2892,
  output logic N2899
);

  logic [DATA_W-1:0] data_in_s, data_s, corr_s, dout_s, dout_r;
  logic [CHK_W-1:0]  chk_in_s, chk_s, syn_raw_s, syn_s, syn_r;
  logic [10:0]       ctl_in_s, ctl_s;
  logic              corr_en_s, det_en_s, oe_lo_s, oe_hi_s, inv_chk_s;
  logic [CHK_W-1:0]  syn_en_s;
  err_class_t        cls_s;
  logic [2:0]        flags_s, flags_r;

  assign data_in_s = {N1, N4, N7, N10, N13, N16, N19, N22,
                      N25, N28, N31, N34, N37, N40, N43, N46};
  assign chk_in_s  = {N49, N53, N56, N60, N63, N66};
  assign ctl_in_s  = {N69, N72, N76, N79, N82, N85, N88, N91, N94, N99, N104};

`ifdef C1908_IN_REG_EN
  logic [DATA_W-1:0] data_r;
  logic [CHK_W-1:0]  chk_r;
  logic [10:0]       ctl_r;

  // Optional input capture stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= '0;
      chk_r  <= '0;
      ctl_r  <= '0;
    end else begin
      data_r <= data_in_s;
      chk_r  <= chk_in_s;
      ctl_r  <= ctl_in_s;
    end
  end

  assign data_s = data_r;
  assign chk_s  = chk_r;
  assign ctl_s  = ctl_r;
`else
  assign data_s = data_in_s;
  assign chk_s  = chk_in_s;
  assign ctl_s  = ctl_in_s;
`endif

  assign {corr_en_s, det_en_s, oe_lo_s, oe_hi_s, inv_chk_s, syn_en_s} = ctl_s;

  c1908_syndrome u_syndrome (
    .data    (data_s),
    .chk     (chk_s),
    .inv_chk (inv_chk_s),
    .syn_raw (syn_raw_s)
  );

  // Classify the masked syndrome, correct a single data error, gate bytes and flags
  always_comb begin
    syn_s = syn_raw_s & syn_en_s;
    if (syn_s == 6'd0) begin
      cls_s = NONE;
    end else if (syn_s[5] == 1'b0) begin
      cls_s = DOUBLE;
    end else if (syn_s[4:0] <= MAX_POS) begin
      cls_s = SINGLE;  // includes s=0, i.e. c5 itself flipped
    end else begin
      cls_s = DOUBLE;
    end

    corr_s = data_s;
    for (int i = 0; i < DATA_W; i++) begin
      if (corr_en_s && (cls_s == SINGLE) && (DATA_POS[i] == syn_s[4:0])) begin
        corr_s[i] = ~data_s[i];
      end else begin
        corr_s[i] = data_s[i];
      end
    end

    dout_s = {oe_hi_s ? corr_s[15:8] : 8'h00, oe_lo_s ? corr_s[7:0] : 8'h00};

    flags_s = 3'b000;
    if (det_en_s) begin
      case (cls_s)
        NONE:    flags_s = 3'b100;
        SINGLE:  flags_s = 3'b010;
        DOUBLE:  flags_s = 3'b001;
        default: flags_s = 3'b001;
      endcase
    end else begin
      flags_s = 3'b000;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r  <= '0;
      syn_r   <= '0;
      flags_r <= 3'b100;
    end else begin
      dout_r  <= dout_s;
      syn_r   <= syn_s;
      flags_r <= flags_s;
    end
  end

  assign {N2753, N2754, N2755, N2756, N2762, N2767, N2768, N2779,
          N2780, N2781, N2782, N2783, N2784, N2785, N2786, N2787} = dout_r;
  assign {N2886, N2887, N2888, N2889, N2890, N2891} = syn_r;
  assign {N2811, N2892, N2899} = flags_r;

endmodule

// File: tb/tb_c1908_sec_ded.sv
// Scoreboard bench for c1908_sec_ded: expectations are queued at drive time
// and compared when the pipelined result emerges.
module tb_c1908_sec_ded;

`ifdef C1908_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [10:0] NORM = 11'b11110111111;
  localparam int DPOS [16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

  typedef struct packed {
    logic [15:0] dout;
    logic [5:0]  syn;
    logic        ne;
    logic        se;
    logic        de;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [5:0]  chk = 6'h00;
  logic [10:0] ctl = 11'h000;

  logic [15:0] dout_o;
  logic [5:0]  syn_o;
  logic        ne_o, se_o, de_o;

  exp_t  exp_q [$];
  string tag_q [$];
  int    n_run = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  c1908_sec_ded dut (
    .clk(clk), .rst_n(rst_n),
    .N1(data[15]), .N4(data[14]), .N7(data[13]), .N10(data[12]),
    .N13(data[11]), .N16(data[10]), .N19(data[9]), .N22(data[8]),
    .N25(data[7]), .N28(data[6]), .N31(data[5]), .N34(data[4]),
    .N37(data[3]), .N40(data[2]), .N43(data[1]), .N46(data[0]),
    .N49(chk[5]), .N53(chk[4]), .N56(chk[3]), .N60(chk[2]), .N63(chk[1]), .N66(chk[0]),
    .N69(ctl[10]), .N72(ctl[9]), .N76(ctl[8]), .N79(ctl[7]), .N82(ctl[6]),
    .N85(ctl[5]), .N88(ctl[4]), .N91(ctl[3]), .N94(ctl[2]), .N99(ctl[1]), .N104(ctl[0]),
    .N2753(dout_o[15]), .N2754(dout_o[14]), .N2755(dout_o[13]), .N2756(dout_o[12]),
    .N2762(dout_o[11]), .N2767(dout_o[10]), .N2768(dout_o[9]), .N2779(dout_o[8]),
    .N2780(dout_o[7]), .N2781(dout_o[6]), .N2782(dout_o[5]), .N2783(dout_o[4]),
    .N2784(dout_o[3]), .N2785(dout_o[2]), .N2786(dout_o[1]), .N2787(dout_o[0]),
    .N2811(ne_o),
    .N2886(syn_o[5]), .N2887(syn_o[4]), .N2888(syn_o[3]),
    .N2889(syn_o[2]), .N2890(syn_o[1]), .N2891(syn_o[0]),
    .N2892(se_o),
    .N2899(de_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic [5:0] s,
                              input logic ne, input logic se, input logic de);
    exp_t e;
    e.dout = d; e.syn = s; e.ne = ne; e.se = se; e.de = de; e.valid = 1'b1;
    return e;
  endfunction

  // Reference encoder: check bits that make the codeword error-free
  function automatic logic [5:0] enc(input logic [15:0] d);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) s = s ^ 5'(DPOS[i]);
    end
    return {(^d) ^ (^s), s};
  endfunction

  task automatic send(input logic [15:0] d, input logic [5:0] c, input logic [10:0] k,
                      input exp_t e, input string tag);
    exp_t got_e;
    string t;
    @(negedge clk);
    data = d; chk = c; ctl = k;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() >= LAT) begin
      got_e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (got_e.valid) begin
        check_val(t, {7'd0, dout_o, syn_o, ne_o, se_o, de_o},
                  {7'd0, got_e.dout, got_e.syn, got_e.ne, got_e.se, got_e.de});
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    data = 16'hFFFF; chk = 6'h2A; ctl = NORM;
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    check_val(tag, {7'd0, dout_o, syn_o, ne_o, se_o, de_o},
              {7'd0, 16'h0000, 6'h00, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t none_e;
    logic [15:0] d, m;
    int i, j;
    none_e = '0;

    repeat (2) @(posedge clk);
    #1;
    check_val("reset_init", {7'd0, dout_o, syn_o, ne_o, se_o, de_o},
              {7'd0, 16'h0000, 6'h00, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h0000, 6'h00, NORM, mk(16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0), "no_err");
    send(16'h0001, 6'h00, NORM, mk(16'h0000, 6'b100011, 1'b0, 1'b1, 1'b0), "single_corr");
    send(16'h0001, 6'h00, NORM & 11'b01111111111,
         mk(16'h0001, 6'b100011, 1'b0, 1'b1, 1'b0), "single_nocorr");
    send(16'h0003, 6'h00, NORM, mk(16'h0003, 6'b000110, 1'b0, 1'b0, 1'b1), "double");
    send(16'h0000, 6'h3F, NORM | 11'b00001000000,
         mk(16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0), "inv_chk");
    send(16'hABCD, enc(16'hABCD), NORM & 11'b11101111111,
         mk(16'h00CD, 6'b000000, 1'b1, 1'b0, 1'b0), "hi_gate");
    send(16'hABCD, enc(16'hABCD), NORM & 11'b11011111111,
         mk(16'hAB00, 6'b000000, 1'b1, 1'b0, 1'b0), "lo_gate");
    send(16'h0001, 6'h00, NORM & 11'b10111111111,
         mk(16'h0000, 6'b100011, 1'b0, 1'b0, 1'b0), "det_off");
    send(16'h0001, 6'h00, NORM & 11'b11111000000,
         mk(16'h0001, 6'b000000, 1'b1, 1'b0, 1'b0), "syn_mask");
    send(16'hABCD, enc(16'hABCD) ^ 6'b000100, NORM,
         mk(16'hABCD, 6'b100100, 1'b0, 1'b1, 1'b0), "chk_bit_err");
    send(16'hABCD, enc(16'hABCD) ^ 6'b100000, NORM,
         mk(16'hABCD, 6'b100000, 1'b0, 1'b1, 1'b0), "c5_err");
    send(16'h5A5A, enc(16'h5A5A) ^ 6'b010110, NORM,
         mk(16'h5A5A, 6'b110110, 1'b0, 1'b0, 1'b1), "uncorrectable");
    send(16'h8000, enc(16'h0000), NORM, mk(16'h0000, 6'b110101, 1'b0, 1'b1, 1'b0), "msb_err");

    do_reset("reset_mid");
    send(16'h1234, enc(16'h1234), NORM, mk(16'h1234, 6'b000000, 1'b1, 1'b0, 1'b0), "post_reset");

    for (int n = 0; n < 16; n++) begin
      d = 16'($urandom);
      i = $urandom_range(0, 15);
      j = (i + 1 + $urandom_range(0, 14)) % 16;
      m = 16'(1) << i;
      send(d, enc(d), NORM, mk(d, 6'b000000, 1'b1, 1'b0, 1'b0), "rand_clean");
      send(d ^ m, enc(d), NORM, mk(d, {1'b1, 5'(DPOS[i])}, 1'b0, 1'b1, 1'b0), "rand_single");
      m = m | (16'(1) << j);
      send(d ^ m, enc(d), NORM,
           mk(d ^ m, {1'b0, 5'(DPOS[i] ^ DPOS[j])}, 1'b0, 1'b0, 1'b1), "rand_double");
    end

    repeat (LAT) send(16'h0000, 6'h00, NORM, none_e, "flush");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/c1908_sec_ded.md
# c1908_sec_ded

Registered 16-bit single-error-correcting / double-error-detecting (SEC/DED) Hamming decoder with the ISCAS-85 c1908 port map. It takes 16 data bits and 6 check bits plus 11 control bits. It produces 16 corrected data bits, the 6-bit syndrome and three error flags. It sits on a memory or bus read path and exposes the c1908 pin names, so it is a drop-in replacement.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; **synchronous, active-low**, single clock domain
- `N1,N4,N7,N10,N13,N16,N19,N22,N25,N28,N31,N34,N37,N40,N43,N46`  in  1 each  `data[15:0]`, MSB first
- `N49,N53,N56,N60,N63,N66`  in  1 each  `chk[5:0]`: `N49`=c5 (overall parity), `N66`=c0
- `N69`  in  1  `corr_en`
- `N72`  in  1  `det_en`
- `N76` / `N79`  in  1  `out_en_lo` / `out_en_hi` (enables for the low and high output bytes)
- `N82`  in  1  `inv_chk`: invert all check bits before decoding
- `N85,N88,N91,N94,N99,N104`  in  1 each  `syn_en[5:0]`: per-bit syndrome enable, `N85` is bit 5
- `N2753,N2754,N2755,N2756,N2762,N2767,N2768,N2779..N2787`  out  1 each  `dout[15:0]`, MSB first
- `N2811`  out  1  `no_err`
- `N2886..N2891`  out  1 each  `syn[5:0]`, `N2886`=syn[5]
- `N2892`  out  1  `single_err`
- `N2899`  out  1  `double_err`

## Operation
- **Codeword layout.** Positions 1..21.
  - Check bits c0..c4 sit at positions 1, 2, 4, 8, 16.
  - data[0..15] sit, in ascending order, at positions 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21.
  - c5 makes the XOR of all 22 bits even.
- **Syndrome.**
  - If `inv_chk`=1, use ~chk; otherwise use chk.
  - s[k] (k=0..4) = XOR of every received bit at a position whose bit k is 1, including the check bit itself.
  - p = XOR of all 22 received bits.
  - Raw syndrome = {p, s[4:0]}. Masked syndrome `syn` = raw & `syn_en`. All decode decisions use the masked value.
- **Classification** (s = syn[4:0], p = syn[5]):
  - s=0, p=0: no error.
  - p=1, s in 1..21: single error at position s.
  - p=1, s=0: single error in c5.
  - p=1, s in 22..31: uncorrectable; treat as double.
  - p=0, s≠0: double error.
- **Correction.** If `corr_en`=1 and the result is a single error at a data position, flip that data bit. In every other case, dout = data unchanged.
- **Byte gating.** dout[7:0] is forced to 0 when `out_en_lo`=0. dout[15:8] is forced to 0 when `out_en_hi`=0.
- **Flags.** When `det_en`=1, exactly one of `no_err`, `single_err`, `double_err` is 1. When `det_en`=0, all three are 0.
- **Syndrome output.** `syn` is always output, regardless of `det_en`.

## Timing
- Decoding is combinational. All 25 outputs are registered on the rising edge of `clk`, giving 1-cycle latency.
- Inputs are sampled on the edge; the result is visible on the same edge's register output.
- A new vector can be applied every cycle; there is no handshake.
- Reset, when `rst_n`=0 at a rising edge:
  - dout = 0, syn = 0, single_err = 0, double_err = 0, no_err = 1.
  - Reset overrides any in-flight decode.
  - The first valid result appears on the first edge after `rst_n` rises.

## Configuration
- `C1908_IN_REG_EN` defined: add an input register stage on all 33 inputs, also reset by `rst_n` to 0. Latency becomes 2 cycles.
- `C1908_IN_REG_EN` undefined: inputs feed the decoder directly. Latency is 1 cycle.

## Structure
- Package `c1908_pkg` holds:
  - the data-to-position map as a constant array;
  - check-position constants;
  - the widths DATA_W=16 and CHK_W=6;
  - typedef `err_class_t` (NONE, SINGLE, DOUBLE).
- Sub-module `c1908_syndrome`: a combinational block that computes the syndrome from data, chk and `inv_chk`. The top level does masking, correction, gating and registering.

## Test plan
In every line below the control word is "normal" unless stated otherwise: `N69..N104` = 11'b11110111111.
- **No error.** data=0x0000, chk=0x00 -> next cycle dout=0x0000, syn=0, no_err=1.
- **Single data error.** data=0x0001, chk=0x00 -> syn=6'b100011, single_err=1, dout=0x0000. Repeat with `N69`=0 -> dout=0x0001.
- **Double error.** data=0x0003, chk=0x00 -> syn=6'b000110, double_err=1, dout=0x0003.
- **Check inversion and byte gating.**
  - data=0x0000, chk=0x3F with `inv_chk`=1 -> no_err=1.
  - data=0xABCD with an error-free chk, `out_en_hi`=0 -> dout=0x00CD.
- **Flag and mask gating.**
  - `det_en`=0 on the single-error vector -> all flags 0, syn still 6'b100011.
  - `syn_en`=0 -> syn=0, dout=data.
- **Reset.** Assert `rst_n`=0 mid-stream -> the next edge gives dout=0, syn=0, no_err=1. Release `rst_n` -> results resume at 1-cycle latency, or 2 cycles with `C1908_IN_REG_EN` defined.
